// File: rtl/rgmii_pkg.sv
// Shared constants for the RGMII receive clock-enable generator.
package rgmii_pkg;

  localparam logic SPEED_1000   = 1'b1;
  localparam logic SPEED_10_100 = 1'b0;

  localparam int unsigned DEF_RST_SYNC_LEN = 4;
  localparam int unsigned DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/rgmii_bit_sync.sv
// N-flop single-bit synchronizer with asynchronous active-low reset to RST_VAL.
module rgmii_bit_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rgmii_rx_clkgen.sv
// RGMII receive clock-enable generator: divide-by-2 phase, glitch-free speed-selected
// enable and synchronously released datapath reset. Optional debug counters: RGMII_RX_CLKGEN_DBG_EN.
module rgmii_rx_clkgen
  import rgmii_pkg::*;
#(
  parameter int unsigned RST_SYNC_LEN = DEF_RST_SYNC_LEN,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic       rgmii_rxclk,
  input  logic       reset_n,
  input  logic       speed,
  output logic       clk_div,
  output logic       div_ce,
  output logic       rxclk_ce,
  output logic       speed_sel,
  output logic       switch_pulse,
  output logic       rst_in
`ifdef RGMII_RX_CLKGEN_DBG_EN
  ,
  output logic [7:0] dbg_switch_cnt,
  output logic [3:0] dbg_rst_cnt
`endif
);

  logic                    speed_s;
  logic [RST_SYNC_LEN-1:0] rst_sr;

  rgmii_bit_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SPEED_1000)
  ) u_speed_sync (
    .clk   (rgmii_rxclk),
    .rst_n (reset_n),
    .d     (speed),
    .q     (speed_s)
  );

  // Speed only changes on the 1->0 edge of clk_div so no divided period is cut short.
  always_ff @(posedge rgmii_rxclk or negedge reset_n) begin
    if (!reset_n) begin
      clk_div      <= 1'b0;
      rst_sr       <= '0;
      speed_sel    <= SPEED_1000;
      switch_pulse <= 1'b0;
    end else begin
      clk_div      <= ~clk_div;
      switch_pulse <= 1'b0;
      if (!clk_div) begin
        rst_sr <= {rst_sr[RST_SYNC_LEN-2:0], 1'b1};
      end
      if (clk_div) begin
        speed_sel    <= speed_s;
        switch_pulse <= (speed_s != speed_sel);
      end
    end
  end

  assign div_ce   = clk_div;
  assign rst_in   = ~rst_sr[RST_SYNC_LEN-1];
  assign rxclk_ce = ~rst_in & (speed_sel | div_ce);

`ifdef RGMII_RX_CLKGEN_DBG_EN
  // Switch counter wraps; reset-cycle counter saturates.
  always_ff @(posedge rgmii_rxclk or negedge reset_n) begin
    if (!reset_n) begin
      dbg_switch_cnt <= 8'd0;
      dbg_rst_cnt    <= 4'd0;
    end else begin
      if (switch_pulse) begin
        dbg_switch_cnt <= dbg_switch_cnt + 8'd1;
      end
      if (rst_in && (dbg_rst_cnt != 4'hF)) begin
        dbg_rst_cnt <= dbg_rst_cnt + 4'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rgmii_rx_clkgen.sv
// Directed self-checking bench for rgmii_rx_clkgen; define RGMII_RX_CLKGEN_DBG_EN to cover debug counters.
module tb_rgmii_rx_clkgen;

  logic       rgmii_rxclk = 1'b0;
  logic       reset_n     = 1'b0;
  logic       speed       = 1'b1;
  logic       clk_div;
  logic       div_ce;
  logic       rxclk_ce;
  logic       speed_sel;
  logic       switch_pulse;
  logic       rst_in;
`ifdef RGMII_RX_CLKGEN_DBG_EN
  logic [7:0] dbg_switch_cnt;
  logic [3:0] dbg_rst_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;
  logic prev_ce;

  rgmii_rx_clkgen dut (
    .rgmii_rxclk  (rgmii_rxclk),
    .reset_n      (reset_n),
    .speed        (speed),
    .clk_div      (clk_div),
    .div_ce       (div_ce),
    .rxclk_ce     (rxclk_ce),
    .speed_sel    (speed_sel),
    .switch_pulse (switch_pulse),
    .rst_in       (rst_in)
`ifdef RGMII_RX_CLKGEN_DBG_EN
    ,
    .dbg_switch_cnt (dbg_switch_cnt),
    .dbg_rst_cnt    (dbg_rst_cnt)
`endif
  );

  always #4 rgmii_rxclk = ~rgmii_rxclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  // Advance to just after rising edge k (counted from the last reset release).
  task automatic go_to(input int k);
    while (edge_n < k) begin
      @(posedge rgmii_rxclk);
      edge_n++;
    end
    #1;
  endtask

  task automatic release_rst();
    @(negedge rgmii_rxclk);
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".clk_div"},      8'(clk_div),      8'd0);
    chk({tag, ".div_ce"},       8'(div_ce),       8'd0);
    chk({tag, ".rxclk_ce"},     8'(rxclk_ce),     8'd0);
    chk({tag, ".switch_pulse"}, 8'(switch_pulse), 8'd0);
    chk({tag, ".rst_in"},       8'(rst_in),       8'd1);
    chk({tag, ".speed_sel"},    8'(speed_sel),    8'd1);
`ifdef RGMII_RX_CLKGEN_DBG_EN
    chk({tag, ".dbg_switch_cnt"}, dbg_switch_cnt,   8'd0);
    chk({tag, ".dbg_rst_cnt"},    8'(dbg_rst_cnt),  8'd0);
`endif
  endtask

  initial begin
    // Power-on reset at 1000M, then release
    #20;
    chk_reset_state("por");
    release_rst();
    go_to(1); chk("div_e1", 8'(clk_div), 8'd1); chk("rst_e1", 8'(rst_in), 8'd1);
    go_to(2); chk("div_e2", 8'(clk_div), 8'd0);
    go_to(3); chk("div_e3", 8'(clk_div), 8'd1);
    go_to(4); chk("div_e4", 8'(clk_div), 8'd0);
    go_to(6); chk("rst_e6", 8'(rst_in), 8'd1); chk("ce_e6", 8'(rxclk_ce), 8'd0);
    go_to(7); chk("rst_e7", 8'(rst_in), 8'd0); chk("ce_e7", 8'(rxclk_ce), 8'd1);
    go_to(8); chk("ce_e8", 8'(rxclk_ce), 8'd1);
    go_to(9); chk("ce_e9", 8'(rxclk_ce), 8'd1);
    chk("sel_e9", 8'(speed_sel), 8'd1); chk("pulse_e9", 8'(switch_pulse), 8'd0);
`ifdef RGMII_RX_CLKGEN_DBG_EN
    chk("dbg_rst_sat", 8'(dbg_rst_cnt), 8'd7);
`endif

    // 10/100M held through reset: switch lands on edge 4
    @(negedge rgmii_rxclk);
    reset_n = 1'b0;
    speed   = 1'b0;
    #1;
    chk_reset_state("rst2");
    release_rst();
    go_to(3); chk("sel_e3", 8'(speed_sel), 8'd1); chk("pulse_e3", 8'(switch_pulse), 8'd0);
    go_to(4); chk("sel_e4", 8'(speed_sel), 8'd0); chk("pulse_e4", 8'(switch_pulse), 8'd1);
    go_to(5); chk("pulse_e5", 8'(switch_pulse), 8'd0);
    for (int k = 7; k <= 10; k++) begin
      go_to(k);
      chk("ce_slow", 8'(rxclk_ce), 8'(k % 2));
      chk("dce_slow", 8'(div_ce), 8'(k % 2));
    end

    // One-cycle glitch whose synced copy is gone before the next boundary
    speed = 1'b1;
    go_to(11);
    speed = 1'b0;
    for (int k = 11; k <= 16; k++) begin
      go_to(k);
      chk("glitch_sel", 8'(speed_sel), 8'd0);
      chk("glitch_pulse", 8'(switch_pulse), 8'd0);
    end

    // 0->1 switch requested just after edge 20
    go_to(20);
    speed   = 1'b1;
    prev_ce = rxclk_ce;
    for (int k = 21; k <= 23; k++) begin
      go_to(k);
      chk("pre_sw_sel", 8'(speed_sel), 8'd0);
      chk("pre_sw_ce", 8'(rxclk_ce), 8'(k % 2));
      chk("pre_sw_dbl", 8'(prev_ce & rxclk_ce), 8'd0);
      prev_ce = rxclk_ce;
    end
    go_to(24);
    chk("sw_sel", 8'(speed_sel), 8'd1);
    chk("sw_pulse", 8'(switch_pulse), 8'd1);
    chk("sw_ce", 8'(rxclk_ce), 8'd1);
    go_to(25); chk("sw_pulse_e25", 8'(switch_pulse), 8'd0); chk("ce_e25", 8'(rxclk_ce), 8'd1);
    go_to(26); chk("ce_e26", 8'(rxclk_ce), 8'd1);
`ifdef RGMII_RX_CLKGEN_DBG_EN
    chk("dbg_sw2", dbg_switch_cnt, 8'd2);
`endif

    // Mid-operation asynchronous reset, then re-release
    go_to(30);
    reset_n = 1'b0;
    #1;
    chk_reset_state("rst3");
    release_rst();
    go_to(6); chk("rr_rst_e6", 8'(rst_in), 8'd1);
    go_to(7); chk("rr_rst_e7", 8'(rst_in), 8'd0);

    // Three speed toggles ten edges apart
    go_to(10); speed = 1'b0;
    go_to(13); chk("t1_sel_e13", 8'(speed_sel), 8'd1);
    go_to(14); chk("t1_sel_e14", 8'(speed_sel), 8'd0);
    go_to(20); speed = 1'b1;
    go_to(24); chk("t2_sel_e24", 8'(speed_sel), 8'd1);
    go_to(30); speed = 1'b0;
    go_to(40); chk("t3_sel_e40", 8'(speed_sel), 8'd0);
`ifdef RGMII_RX_CLKGEN_DBG_EN
    chk("dbg_sw3", dbg_switch_cnt, 8'd3);
    chk("dbg_rst_sat2", 8'(dbg_rst_cnt), 8'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
